// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Revision : 1.0
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_res;
  logic [WIDTH-1:0] r_b;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;
  logic             w_d_bit;
  logic             w_bw_next;
  logic             w_last;

  assign w_d_bit   = r_a_res[0] ^ r_b[0] ^ r_bw;
  assign w_bw_next = (~r_a_res[0] & r_b[0]) | (~(r_a_res[0] ^ r_b[0]) & r_bw);
  assign w_last    = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = FIN;
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (w_state_next == RUN);
      done <= (w_state_next == FIN);
    end
  end

  // The minuend register doubles as the result register: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_res <= '0;
      r_b     <= '0;
      r_bw    <= 1'b0;
      r_cnt   <= '0;
      d       <= '0;
      bo      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_res <= a;
            r_b     <= b;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_res <= {w_d_bit, r_a_res[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_bw    <= w_bw_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            d  <= {w_d_bit, r_a_res[WIDTH-1:1]};
            bo <= w_bw_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .d    (d),
    .bo   (bo)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned m;
    m = ((int'(x) - int'(y)) + 256) % 256;
    return m[W-1:0];
  endfunction

  // Reset asserted together with START: nothing may be accepted.
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_d got=%h want=00", d); end
    total++; if (bo !== 1'b0) begin bad++; $display("FAIL reset_bo got=%b want=0", bo); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string nm);
    logic [W-1:0] exp_d;
    logic         exp_bo;
    exp_d  = ref_diff(ta, tb_v);
    exp_bo = (ta < tb_v);
    @(negedge clk); start = 1'b1; a = ta; b = tb_v;
    @(negedge clk); start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL %s_run cyc=%0d busy=%b done=%b want busy=1 done=0", nm, i, busy, done);
      end
      @(negedge clk);
    end
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s_done done=%b busy=%b want 1/0", nm, done, busy); end
    total++; if (d !== exp_d) begin bad++; $display("FAIL %s_d got=%h want=%h", nm, d, exp_d); end
    total++; if (bo !== exp_bo) begin bad++; $display("FAIL %s_bo got=%b want=%b", nm, bo, exp_bo); end
    @(negedge clk);
    total++; if (done !== 1'b0 || d !== exp_d) begin bad++; $display("FAIL %s_idle done=%b d=%h want 0/%h", nm, done, d, exp_d); end
  endtask

  task automatic test_directed();
    test_op(8'h05, 8'h03, "sub_5_3");
    test_op(8'h03, 8'h05, "sub_3_5");
    test_op(8'h00, 8'h01, "sub_0_1");
    test_op(8'hFF, 8'h00, "sub_ff_0");
    test_op(8'h00, 8'h00, "sub_0_0");
  endtask

  // START re-pulsed and operands changed while busy must not disturb the result.
  task automatic test_ignore_start();
    int ndone;
    ndone = 0;
    @(negedge clk); start = 1'b1; a = 8'h9C; b = 8'h3A;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'h01; b = 8'hF0; end
      else if (i == 4) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        total++; if (d !== 8'h62 || bo !== 1'b0) begin bad++; $display("FAIL ignore_result d=%h bo=%b want 62/0", d, bo); end
      end
      @(negedge clk);
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
  endtask

  // Reset in the 4th RUN cycle aborts the operation; a fresh one then works.
  task automatic test_reset_abort();
    int ndone;
    ndone = 0;
    @(negedge clk); start = 1'b1; a = 8'h10; b = 8'h20;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (d !== 8'h00 || bo !== 1'b0) begin bad++; $display("FAIL abort_clear d=%h bo=%b want 00/0", d, bo); end
    for (int i = 0; i < W + 4; i++) begin
      if (done !== 1'b0) ndone++;
      @(negedge clk);
    end
    total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", ndone); end
    test_op(8'h7E, 8'h81, "after_abort");
  endtask

  // START held high: a new operation accepted every W+2 cycles.
  task automatic run_held(input int nops, input bit scramble, input string nm);
    logic [W-1:0] ca;
    logic [W-1:0] cb;
    for (int op = 0; op < nops; op++) begin
      ca = W'($urandom); cb = W'($urandom);
      if (op % 50 == 0) cb = ca;
      start = 1'b1; a = ca; b = cb;
      for (int j = 0; j < W + 2; j++) begin
        @(negedge clk);
        if (scramble && j < W + 1) begin a = W'($urandom); b = W'($urandom); end
        if (j == W) begin
          total++;
          if (done !== 1'b1 || d !== ref_diff(ca, cb) || bo !== (ca < cb)) begin
            bad++;
            $display("FAIL %s op=%0d a=%h b=%h done=%b d=%h bo=%b want 1/%h/%b",
                     nm, op, ca, cb, done, d, bo, ref_diff(ca, cb), ca < cb);
          end
        end else if (!scramble) begin
          total++;
          if (done !== 1'b0 || busy !== (j < W)) begin
            bad++; $display("FAIL %s_timing op=%0d j=%0d done=%b busy=%b", nm, op, j, done, busy);
          end
        end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_held(3, 1'b0, "b2b");
  endtask

  task automatic test_random();
    run_held(1000, 1'b1, "rand");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
